// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: one shared 4-bit adder computes a W-bit sum,
// least-significant nibble first, with the carry held between cycles.

// 4-bit adder with carry in and carry out
module adder_4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       carry_i,
  output logic [3:0] sum_o,
  output logic       overflow_o
);

  // Widen to 5 bits so the carry out lands in the top bit
  assign {overflow_o, sum_o} = 5'(a_i) + 5'(b_i) + 5'(carry_i);

endmodule

module nibble_serial_adder #(
  parameter int unsigned NUM_NIBBLES = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [4*NUM_NIBBLES-1:0]   op_a,
  input  logic [4*NUM_NIBBLES-1:0]   op_b,
  input  logic                       carry_in,
  output logic                       busy,
  output logic                       done,
  output logic [4*NUM_NIBBLES-1:0]   sum,
  output logic                       carry_out
);

  localparam int unsigned W  = 4 * NUM_NIBBLES;
  localparam int unsigned CW = $clog2(NUM_NIBBLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [W-1:0]   a_sh_q;
  logic [W-1:0]   b_sh_q;
  logic           c_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [W-1:0]   sum_q;
  logic           carry_out_q;

  logic [3:0]     nib;
  logic           ovf;
  logic [W-1:0]   acc_d;
  logic           last_nib;

  adder_4bit u_adder (
    .a_i        (a_sh_q[3:0]),
    .b_i        (b_sh_q[3:0]),
    .carry_i    (c_q),
    .sum_o      (nib),
    .overflow_o (ovf)
  );

  assign last_nib = (cnt_q == CW'(NUM_NIBBLES - 1));

  // Accumulator holds the nibbles already produced; the new nibble enters at the top
  if (NUM_NIBBLES == 1) begin : g_one
    assign acc_d = nib;
  end else begin : g_multi
    logic [W-5:0] acc_q;

    assign acc_d = {nib, acc_q};

    // Shift produced nibbles right as each new one arrives
    always_ff @(posedge clk) begin
      if (rst) begin
        acc_q <= '0;
      end else if (state_q == S_ADD) begin
        acc_q <= acc_d[W-1:4];
      end
    end
  end

  // Sequencer: capture operands, step one nibble per cycle, publish result
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      c_q         <= 1'b0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q  <= op_a;
            b_sh_q  <= op_b;
            c_q     <= carry_in;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_ADD;
          end
        end
        S_ADD: begin
          a_sh_q <= a_sh_q >> 4;
          b_sh_q <= b_sh_q >> 4;
          c_q    <= ovf;
          cnt_q  <= cnt_q + CW'(1);
          if (last_nib) begin
            sum_q       <= acc_d;
            carry_out_q <= ovf;
            busy_q      <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed testbench for nibble_serial_adder (NUM_NIBBLES = 4)
module tb_nibble_serial_adder;

  localparam int unsigned NN = 4;
  localparam int unsigned W  = 4 * NN;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         carry_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry_out;

  int checks   = 0;
  int failures = 0;

  nibble_serial_adder #(.NUM_NIBBLES(NN)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .carry_in  (carry_in),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count one comparison and report it on mismatch
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Launch one op, then wait (bounded) for done; report latency, busy cycles, hold
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        output int lat, output int busy_cycles, output logic held);
    logic [W-1:0] prev;
    @(negedge clk);
    prev     = sum;
    op_a     = a;
    op_b     = b;
    carry_in = cin;
    start    = 1'b1;
    @(negedge clk);
    start       = 1'b0;
    lat         = 0;
    busy_cycles = 0;
    held        = 1'b1;
    while (!done && lat < 20) begin
      if (busy) busy_cycles++;
      if (sum !== prev) held = 1'b0;
      @(negedge clk);
      lat++;
    end
  endtask

  int   lat;
  int   bc;
  logic held;
  int   k;
  int   pulses;

  initial begin
    rst      = 1'b0;
    start    = 1'b0;
    op_a     = '0;
    op_b     = '0;
    carry_in = 1'b0;

    // 1. Reset with start held high
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    op_a  = 16'h1111;
    op_b  = 16'h2222;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_sum", 32'(sum), 32'h0000);
    chk("rst_cout", 32'(carry_out), 32'h0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("rst_no_op", 32'(busy), 32'h0);

    // 2. Basic add
    run_op(16'h1234, 16'h4321, 1'b0, lat, bc, held);
    chk("basic_lat", 32'(lat), 32'd4);
    chk("basic_busy_cycles", 32'(bc), 32'd4);
    chk("basic_sum", 32'(sum), 32'h5555);
    chk("basic_cout", 32'(carry_out), 32'h0);
    chk("basic_busy_at_done", 32'(busy), 32'h0);
    @(negedge clk);
    chk("basic_done_pulse", 32'(done), 32'h0);

    // 6. Result held through ADD, updated at the done edge
    run_op(16'h0001, 16'h0001, 1'b0, lat, bc, held);
    chk("hold_stable", 32'(held), 32'h1);
    chk("hold_lat", 32'(lat), 32'd4);
    chk("hold_sum", 32'(sum), 32'h0002);

    // 3. Full ripple
    run_op(16'hFFFF, 16'h0001, 1'b0, lat, bc, held);
    chk("ripple1_sum", 32'(sum), 32'h0000);
    chk("ripple1_cout", 32'(carry_out), 32'h1);
    run_op(16'hFFFF, 16'h0000, 1'b1, lat, bc, held);
    chk("ripple2_sum", 32'(sum), 32'h0000);
    chk("ripple2_cout", 32'(carry_out), 32'h1);
    run_op(16'h7FFF, 16'h0000, 1'b1, lat, bc, held);
    chk("ripple3_sum", 32'(sum), 32'h8000);
    chk("ripple3_cout", 32'(carry_out), 32'h0);

    // 4. Start held high during ADD and DONE is ignored
    @(negedge clk);
    op_a     = 16'h00F0;
    op_b     = 16'h0F10;
    carry_in = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    op_a = 16'hAAAA;
    lat  = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", 32'(lat), 32'd4);
    chk("ign_sum", 32'(sum), 32'h1000);
    chk("ign_cout", 32'(carry_out), 32'h0);
    // After DONE the FSM passes through IDLE and accepts the held start
    k = 0;
    @(negedge clk);
    k++;
    chk("ign_idle_busy", 32'(busy), 32'h0);
    chk("ign_idle_done", 32'(done), 32'h0);
    while (!done && k < 20) begin
      @(negedge clk);
      k++;
      if (k == 2) start = 1'b0;
    end
    chk("ign_second_spacing", 32'(k), 32'(NN + 2));
    chk("ign_second_sum", 32'(sum), 32'hB9BA);
    chk("ign_second_cout", 32'(carry_out), 32'h0);

    // 5. Reset mid-operation
    @(negedge clk);
    op_a     = 16'h8000;
    op_b     = 16'h8000;
    carry_in = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_busy", 32'(busy), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    chk("mid_rst_sum", 32'(sum), 32'h0000);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("mid_rst_no_done", 32'(pulses), 32'd0);
    chk("mid_rst_cout", 32'(carry_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
